// File: rtl/rtc_pkg.sv
// Shared types for the RTC prescaler: FSM state encoding, minimum divisor
// and the pending-configuration record.
package rtc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } rtc_state_e;

    localparam int MIN_DIV       = 2;
    localparam int RTC_DIV_WIDTH = 16;

    // The pending record is sized by RTC_DIV_WIDTH; keep the top's DIV_WIDTH equal to it.
    typedef struct packed {
        logic [RTC_DIV_WIDTH-1:0] div;
        logic                     en;
    } rtc_cfg_t;

endpackage

// File: rtl/rtc_period_counter.sv
// Period counter for the RTC prescaler: cnt register, wrap detection and the
// registered rtc/tick levels derived from the next counter value.
module rtc_period_counter #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 count_en,
    input  logic                 running_next,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic [DIV_WIDTH-1:0] div_next,
    output logic                 wrap,
    output logic                 rtc,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] cnt_next;
    logic                 first;
    logic                 rtc_next;
    logic                 tick_next;

    // The cycle straight after reset acts as a period start so the first tick is immediate.
    assign wrap = first | (cnt == (div - DIV_WIDTH'(1)));

    always_comb begin
        cnt_next  = '0;
        if (count_en && !wrap) begin
            cnt_next = cnt + DIV_WIDTH'(1);
        end
        rtc_next  = running_next & (cnt_next < (div_next >> 1));
        tick_next = running_next & (cnt_next == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            first <= 1'b1;
            rtc   <= 1'b0;
            tick  <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            first <= 1'b0;
            rtc   <= rtc_next;
            tick  <= tick_next;
        end
    end

endmodule

// File: rtl/rtc_prescaler.sv
// Programmable RTC reference generator for the CLINT. Optional free-running
// tick counter output is enabled with macro RTC_PRESCALER_TICK_COUNT_EN.
module rtc_prescaler
    import rtc_pkg::*;
#(
    parameter int DIV_WIDTH   = RTC_DIV_WIDTH,
    parameter int DEFAULT_DIV = 2,
    parameter bit RESET_RUN   = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    input  logic [DIV_WIDTH-1:0] cfg_div_i,
    input  logic                 cfg_en_i,
    output logic                 rtc_o,
    output logic                 tick_o,
    output logic                 running_o,
    output logic [DIV_WIDTH-1:0] div_o
`ifdef RTC_PRESCALER_TICK_COUNT_EN
    ,
    output logic [63:0]          tick_cnt_o
`endif
);

    localparam logic [DIV_WIDTH-1:0] RESET_DIV =
        (DEFAULT_DIV < MIN_DIV) ? DIV_WIDTH'(MIN_DIV) : DIV_WIDTH'(DEFAULT_DIV);
    localparam rtc_state_e RESET_STATE = RESET_RUN ? RUN : IDLE;

    rtc_state_e           state;
    rtc_state_e           state_next;
    rtc_cfg_t             pending;
    rtc_cfg_t             pending_next;
    logic [DIV_WIDTH-1:0] div;
    logic [DIV_WIDTH-1:0] div_next;
    logic                 running_next;
    logic                 accept;
    logic                 wrap;

    function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] d);
        return (d < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV) : d;
    endfunction

    assign cfg_ready_o = !rst_i && (state != PEND);
    assign accept      = cfg_valid_i && cfg_ready_o;
    assign running_o   = (state != IDLE);
    assign div_o       = div;

    always_comb begin
        state_next   = state;
        pending_next = pending;
        div_next     = div;
        running_next = (state != IDLE);
        case (state)
            IDLE: begin
                if (accept) begin
                    div_next     = clamp_div(cfg_div_i);
                    running_next = cfg_en_i;
                    if (cfg_en_i) begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                // The old divisor keeps running; the request is applied at the wrap.
                if (accept) begin
                    pending_next.div = RTC_DIV_WIDTH'(clamp_div(cfg_div_i));
                    pending_next.en  = cfg_en_i;
                    state_next       = PEND;
                end
            end
            PEND: begin
                if (wrap) begin
                    div_next     = DIV_WIDTH'(pending.div);
                    running_next = pending.en;
                    state_next   = pending.en ? RUN : IDLE;
                end
            end
            default: begin
                state_next   = IDLE;
                running_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= RESET_STATE;
            pending <= '0;
            div     <= RESET_DIV;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            div     <= div_next;
        end
    end

    rtc_period_counter #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_period_counter (
        .clk          (clk_i),
        .rst          (rst_i),
        .count_en     (state != IDLE),
        .running_next (running_next),
        .div          (div),
        .div_next     (div_next),
        .wrap         (wrap),
        .rtc          (rtc_o),
        .tick         (tick_o)
    );

`ifdef RTC_PRESCALER_TICK_COUNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tick_cnt_o <= '0;
        end else if (tick_o) begin
            tick_cnt_o <= tick_cnt_o + 64'd1;
        end
    end
`else
    // Tick counter not present in this build.
`endif

endmodule

// File: tb/tb_rtc_prescaler.sv
// Directed self-checking bench for rtc_prescaler; exercises the tick counter
// too when RTC_PRESCALER_TICK_COUNT_EN is defined.
module tb_rtc_prescaler;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_div;
    logic        cfg_en;
    logic        rtc;
    logic        tick;
    logic        running;
    logic [15:0] div;
`ifdef RTC_PRESCALER_TICK_COUNT_EN
    logic [63:0] tick_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int wait_cycles;
    logic [4:0] rtc5_pat;

    rtc_prescaler dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready),
        .cfg_div_i   (cfg_div),
        .cfg_en_i    (cfg_en),
        .rtc_o       (rtc),
        .tick_o      (tick),
        .running_o   (running),
        .div_o       (div)
`ifdef RTC_PRESCALER_TICK_COUNT_EN
        ,
        .tick_cnt_o  (tick_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_div = '0; cfg_en = 1'b0;
        step(); step();
        check_output("reset_rtc", rtc, 0);
        check_output("reset_tick", tick, 0);
        check_output("reset_ready", cfg_ready, 0);
        check_output("reset_div", div, 2);
        check_output("reset_running", running, 1);

        // First cycle after reset release starts a period.
        rst = 1'b0;
        step();
        check_output("first_rtc", rtc, 1);
        check_output("first_tick", tick, 1);
        check_output("first_ready", cfg_ready, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            check_output("div2_rtc", rtc, (i % 2 == 1) ? 1 : 0);
            check_output("div2_tick", tick, (i % 2 == 1) ? 1 : 0);
        end

        // Switch to div=5 from RUN; old period finishes first.
        cfg_valid = 1'b1; cfg_div = 16'd5; cfg_en = 1'b1;
        step();
        check_output("pend_ready", cfg_ready, 0);
        check_output("pend_div", div, 2);
        check_output("pend_running", running, 1);
        cfg_valid = 1'b0;
        step();
        check_output("div5_start_div", div, 5);
        check_output("div5_start_tick", tick, 1);
        check_output("div5_start_rtc", rtc, 1);
        check_output("div5_start_ready", cfg_ready, 1);
        rtc5_pat = 5'b10001;
        for (int i = 0; i < 5; i++) begin
            step();
            check_output("div5_rtc", rtc, rtc5_pat[i]);
            check_output("div5_tick", tick, (i == 4) ? 1 : 0);
        end

        // Switch to div=4; wait for the wrap of the current div=5 period.
        cfg_valid = 1'b1; cfg_div = 16'd4; cfg_en = 1'b1;
        step();
        check_output("div4_req_ready", cfg_ready, 0);
        cfg_valid = 1'b0;
        wait_cycles = 0;
        do begin
            step();
            wait_cycles++;
        end while (!tick && wait_cycles < 10);
        check_output("div4_wait_cycles", wait_cycles, 4);
        check_output("div4_div", div, 4);

        // Disable from RUN at div=4.
        cfg_valid = 1'b1; cfg_div = 16'd4; cfg_en = 1'b0;
        step();
        check_output("dis_req_ready", cfg_ready, 0);
        check_output("dis_req_rtc", rtc, 1);
        cfg_valid = 1'b0;
        step();
        check_output("dis_p2_rtc", rtc, 0);
        check_output("dis_p2_running", running, 1);
        step();
        check_output("dis_p3_rtc", rtc, 0);
        check_output("dis_p3_running", running, 1);
        step();
        check_output("idle_running", running, 0);
        check_output("idle_rtc", rtc, 0);
        check_output("idle_tick", tick, 0);
        check_output("idle_ready", cfg_ready, 1);
        for (int i = 0; i < 6; i++) begin
            step();
            check_output("idle_hold_tick", tick, 0);
            check_output("idle_hold_rtc", rtc, 0);
        end

        // Divisors below 2 clamp to 2.
        cfg_valid = 1'b1; cfg_div = 16'd0; cfg_en = 1'b0;
        step();
        check_output("clamp0_div", div, 2);
        check_output("clamp0_running", running, 0);
        cfg_div = 16'd1; cfg_en = 1'b1;
        step();
        cfg_valid = 1'b0;
        check_output("clamp1_div", div, 2);
        check_output("clamp1_rtc", rtc, 1);
        check_output("clamp1_tick", tick, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_output("clamp_rtc", rtc, (i % 2 == 1) ? 1 : 0);
        end

        // Reset while a div=8 request is pending.
        cfg_valid = 1'b1; cfg_div = 16'd8; cfg_en = 1'b1;
        step();
        check_output("rstpend_ready", cfg_ready, 0);
        cfg_valid = 1'b0;
        rst = 1'b1;
        step();
        check_output("rstpend_div", div, 2);
        check_output("rstpend_rtc", rtc, 0);
        check_output("rstpend_in_reset_ready", cfg_ready, 0);
        rst = 1'b0;
        step();
        check_output("rstpend_rtc_first", rtc, 1);
        check_output("rstpend_tick_first", tick, 1);
        check_output("rstpend_ready_after", cfg_ready, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            check_output("rstpend_rtc_alt", rtc, (i % 2 == 1) ? 1 : 0);
        end
        check_output("rstpend_div_kept", div, 2);

`ifdef RTC_PRESCALER_TICK_COUNT_EN
        rst = 1'b1;
        step();
        check_output("tcnt_reset", tick_cnt, 0);
        rst = 1'b0;
        cfg_valid = 1'b1; cfg_div = 16'd3; cfg_en = 1'b0;
        step();
        cfg_valid = 1'b0;
        step(); step();
        check_output("tcnt_idle_running", running, 0);
        check_output("tcnt_idle_div", div, 3);
        check_output("tcnt_after_first", tick_cnt, 1);
        cfg_valid = 1'b1; cfg_en = 1'b1;
        step();
        cfg_valid = 1'b0;
        check_output("tcnt_run_tick", tick, 1);
        repeat (30) step();
        check_output("tcnt_ten_ticks", tick_cnt, 11);
        check_output("tcnt_tick_phase", tick, 1);
        cfg_valid = 1'b1; cfg_en = 1'b0;
        step();
        cfg_valid = 1'b0;
        repeat (4) step();
        check_output("tcnt_disabled_running", running, 0);
        check_output("tcnt_disabled_hold", tick_cnt, 12);
        cfg_valid = 1'b1; cfg_en = 1'b1;
        step();
        cfg_valid = 1'b0;
        check_output("tcnt_reenable_tick", tick, 1);
        check_output("tcnt_reenable_hold", tick_cnt, 12);
        step();
        check_output("tcnt_reenable_inc", tick_cnt, 13);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
